// File: rtl/byte_serial_add_sequencer.sv
// rtl/byte_serial_add_sequencer.sv - wide adder sequenced over one external WIDTH-bit adder, LSB slice first
module byte_serial_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [WIDTH*WORDS-1:0]   OP_A,
  input  logic [WIDTH*WORDS-1:0]   OP_B,
  input  logic                     CIN,
  output logic [WIDTH-1:0]         ADD_A,
  output logic [WIDTH-1:0]         ADD_B,
  output logic                     ADD_C,
  input  logic [WIDTH-1:0]         ADD_F,
  input  logic                     ADD_E,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [WIDTH*WORDS-1:0]   RESULT,
  output logic                     COUT,
  output logic                     OVF
);

  localparam int N  = WIDTH * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;

  // Adder operands come straight from the registers so the external adder
  // sees a stable slice for the whole RUN cycle.
  always_comb begin
    ADD_A = '0;
    ADD_B = '0;
    ADD_C = 1'b0;
    if (state == RUN) begin
      ADD_A = a_reg[idx*WIDTH +: WIDTH];
      ADD_B = b_reg[idx*WIDTH +: WIDTH];
      ADD_C = carry;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      RESULT <= '0;
      COUT   <= 1'b0;
      OVF    <= 1'b0;
      DONE   <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            a_reg  <= OP_A;
            b_reg  <= OP_B;
            carry  <= CIN;
            idx    <= '0;
            RESULT <= '0;
            COUT   <= 1'b0;
            OVF    <= 1'b0;
            BUSY   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          RESULT[idx*WIDTH +: WIDTH] <= ADD_F;
          carry <= ADD_E;
          if (idx == LAST_IDX) begin
            // Signed overflow: like-signed operands producing a result of the other sign.
            COUT  <= ADD_E;
            OVF   <= (a_reg[N-1] == b_reg[N-1]) && (ADD_F[WIDTH-1] != a_reg[N-1]);
            idx   <= '0;
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_add_sequencer.sv
// tb/tb_byte_serial_add_sequencer.sv - directed and random checks of byte_serial_add_sequencer against a 33-bit sum model
module tb_byte_serial_add_sequencer;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int N = WIDTH * WORDS;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [N-1:0]     OP_A;
  logic [N-1:0]     OP_B;
  logic             CIN;
  logic [WIDTH-1:0] ADD_A;
  logic [WIDTH-1:0] ADD_B;
  logic             ADD_C;
  logic [WIDTH-1:0] ADD_F;
  logic             ADD_E;
  logic             BUSY;
  logic             DONE;
  logic [N-1:0]     RESULT;
  logic             COUT;
  logic             OVF;

  int n_assert = 0;
  int n_fail = 0;

  byte_serial_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP_A(OP_A), .OP_B(OP_B), .CIN(CIN),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_C(ADD_C), .ADD_F(ADD_F), .ADD_E(ADD_E),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT), .OVF(OVF)
  );

  // Behavioural narrow adder wired to the sequencer.
  assign {ADD_E, ADD_F} = {1'b0, ADD_A} + {1'b0, ADD_B} + {{WIDTH{1'b0}}, ADD_C};

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full-width reference: 33-bit sum, overflow from operand and result signs.
  task automatic check_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic c);
    logic [N:0] sum;
    logic ovf;
    sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    chk({tag, "_result"}, RESULT, sum[N-1:0]);
    chk({tag, "_cout"}, COUT, sum[N]);
    chk({tag, "_ovf"}, OVF, ovf);
  endtask

  // Runs one operation; operands are scrambled after acceptance to show they are latched.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c, input bit detail);
    int k;
    START = 1'b1; OP_A = a; OP_B = b; CIN = c;
    tick();
    START = 1'b0; OP_A = $urandom; OP_B = $urandom; CIN = $urandom_range(0, 1);
    if (detail) chk({tag, "_busy_run"}, BUSY, 1'b1);
    k = 0;
    while (!DONE && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, DONE, 1'b1);
    if (detail) chk({tag, "_latency"}, k, WORDS);
    check_result(tag, a, b, c);
    tick();
    chk({tag, "_done_clear"}, DONE, 1'b0);
    if (detail) chk({tag, "_busy_idle"}, BUSY, 1'b0);
  endtask

  initial begin
    logic [N-1:0] a1, b1, a2, b2, ra, rb;
    logic rc;
    int done_cnt;

    RST = 1'b1; START = 1'b0; OP_A = '0; OP_B = '0; CIN = 1'b0;
    #12;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_result", RESULT, 32'h0);
    chk("rst_cout", COUT, 1'b0);
    chk("rst_ovf", OVF, 1'b0);
    chk("rst_add", {ADD_A, ADD_B, ADD_C}, 17'h0);
    RST = 1'b0;
    tick();
    tick();

    // Directed corner cases.
    run_op("t1", 32'h000000FF, 32'h00000001, 1'b0, 1'b1);
    chk("t1_result_hold", RESULT, 32'h00000100);
    run_op("t2", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
    run_op("t3a", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
    run_op("t3b", 32'h80000000, 32'h80000000, 1'b0, 1'b1);
    chk("t3b_ovf_const", {COUT, OVF, RESULT}, {2'b11, 32'h0});

    // START held for 12 edges, operands changed mid-run.
    a1 = 32'h12345678; b1 = 32'h9ABCDEF0; a2 = 32'h0F0F0F0F; b2 = 32'hF0F0F0F1;
    START = 1'b1; OP_A = a1; OP_B = b1; CIN = 1'b0;
    done_cnt = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 1) begin OP_A = a2; OP_B = b2; end
      if (DONE) done_cnt++;
      if (e == 4) begin
        chk("t4_done1", DONE, 1'b1);
        check_result("t4_first", a1, b1, 1'b0);
      end
      if (e == 5) chk("t4_busy_gap", BUSY, 1'b0);
      if (e == 6) chk("t4_busy_again", BUSY, 1'b1);
      if (e == 10) begin
        chk("t4_done2", DONE, 1'b1);
        check_result("t4_second", a2, b2, 1'b0);
      end
    end
    START = 1'b0;
    chk("t4_done_count", done_cnt, 2);
    tick();
    chk("t4_idle", BUSY, 1'b0);

    // Asynchronous reset while idx==2.
    START = 1'b1; OP_A = 32'h11223344; OP_B = 32'h01010101; CIN = 1'b0;
    tick();
    START = 1'b0;
    tick();
    tick();
    chk("t5_add_a_slice2", ADD_A, 8'h22);
    #2 RST = 1'b1;
    #1;
    chk("t5_busy", BUSY, 1'b0);
    chk("t5_result", RESULT, 32'h0);
    chk("t5_cout", COUT, 1'b0);
    chk("t5_add", {ADD_A, ADD_B, ADD_C}, 17'h0);
    #1 RST = 1'b0;
    done_cnt = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (DONE) done_cnt++;
    end
    chk("t5_no_done", done_cnt, 0);
    run_op("t5_after", 32'hDEADBEEF, 32'h21524111, 1'b1, 1'b1);

    // Random sweep.
    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom_range(0, 1);
      if (i % 10 == 0) ra[N-1] = rb[N-1];
      run_op("rand", ra, rb, rc, (i < 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
